dac_cmd_sched: RTL and testbench



---
 rtl/dac_cmd_sched.sv | 196 +++++++++++++++++++
 tb/tb_dac_cmd_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cmd_sched.sv
// rtl/dac_cmd_sched.sv - round-robin scheduler sharing one DAC write port between axis current commands
// Define DAC_WATCHDOG_EN to add per-axis command watchdogs that park stale axes (adds wd_trip).
module dac_cmd_sched #(
   parameter int          NUM_CH      = 4,
   parameter int          ACK_TIMEOUT = 64,
   parameter logic [15:0] PARK_CODE   = 16'h8000
`ifdef DAC_WATCHDOG_EN
   ,
   parameter logic [23:0] WD_CYCLES   = 24'd491520
`endif
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NUM_CH-1:0]     ctrl_enable,
   input  logic [NUM_CH-1:0]     cmd_ready,
   input  logic [16*NUM_CH-1:0]  cmd_data,
   input  logic                  dac_busy,
   output logic                  dac_start,
   output logic [2:0]            dac_ch,
   output logic [15:0]           dac_data,
   output logic [NUM_CH-1:0]     pending,
   output logic [NUM_CH-1:0]     overrun,
   output logic                  ack_err,
`ifdef DAC_WATCHDOG_EN
   output logic [NUM_CH-1:0]     wd_trip,
`endif
   input  logic                  err_clr
);

   localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CW1 = CW + 1;
   localparam int AW  = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

   state_t            state, state_nxt;
   logic [NUM_CH-1:0] rdy_s1, rdy_s2, rdy_d;
   logic [NUM_CH-1:0] en_s1, en_s2, en_d;
   logic [NUM_CH-1:0] cap, park, park_load, load, issue_mask, ovr_set, wd_fire;
   logic [15:0]       slot [NUM_CH];
   logic [CW-1:0]     rr, sel;
   logic [CW1-1:0]    sum;
   logic [AW-1:0]     ack_cnt;
   logic              issue, ack_to;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdy_s1 <= '0;
         rdy_s2 <= '0;
         rdy_d  <= '0;
         en_s1  <= '0;
         en_s2  <= '0;
         en_d   <= '0;
      end else begin
         rdy_s1 <= cmd_ready;
         rdy_s2 <= rdy_s1;
         rdy_d  <= rdy_s2;
         en_s1  <= ctrl_enable;
         en_s2  <= en_s1;
         en_d   <= en_s2;
      end
   end

   // The enable gate keeps capture and park mutually exclusive on an axis.
   assign cap  = rdy_s2 & ~rdy_d & en_s2;
   assign park = en_d & ~en_s2;

   // First pending axis at or after rr; scanning downward lets the nearest one win.
   always_comb begin
      sel = '0;
      sum = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         sum = {1'b0, rr} + CW1'(i);
         if (sum >= CW1'(NUM_CH))
            sum = sum - CW1'(NUM_CH);
         if (pending[sum[CW-1:0]])
            sel = sum[CW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      ack_to    = 1'b0;
      dac_start = 1'b0;
      case (state)
         IDLE: begin
            if (|pending && !dac_busy) begin
               issue     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            dac_start = 1'b1;
            state_nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (dac_busy)
               state_nxt = WAIT_LO;
            else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
               ack_to    = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT_LO: begin
            if (!dac_busy)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ack_cnt <= '0;
      else if (state != WAIT_HI)
         ack_cnt <= '0;
      else
         ack_cnt <= ack_cnt + AW'(1);
   end

   always_comb begin
      issue_mask = '0;
      if (issue)
         issue_mask[sel] = 1'b1;
      park_load = park | wd_fire;
      load      = park_load | cap;
      ovr_set   = cap & pending & ~issue_mask;
   end

   // The grant reads the slot before any same-cycle capture lands; capture re-sets pending.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dac_ch   <= '0;
         dac_data <= 16'h8000;
         rr       <= '0;
         pending  <= '0;
         overrun  <= '0;
         ack_err  <= 1'b0;
         for (int k = 0; k < NUM_CH; k++)
            slot[k] <= 16'h8000;
      end else begin
         if (issue) begin
            dac_ch   <= 3'(sel);
            dac_data <= slot[sel];
            rr       <= (sel == CW'(NUM_CH - 1)) ? '0 : sel + CW'(1);
         end
         pending <= (pending & ~issue_mask) | load;
         overrun <= (overrun & ~{NUM_CH{err_clr}}) | ovr_set;
         ack_err <= (ack_err & ~err_clr) | ack_to;
         for (int k = 0; k < NUM_CH; k++) begin
            if (park_load[k])
               slot[k] <= PARK_CODE;
            else if (cap[k])
               slot[k] <= cmd_data[16*k +: 16];
         end
      end
   end

`ifdef DAC_WATCHDOG_EN
   logic [23:0] wd_cnt [NUM_CH];

   always_comb begin
      wd_fire = '0;
      for (int k = 0; k < NUM_CH; k++)
         wd_fire[k] = en_s2[k] & ~cap[k] & (wd_cnt[k] == WD_CYCLES - 24'd1);
   end

   // Counter saturates at WD_CYCLES so a stale axis parks only once until its next command.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_trip <= '0;
         for (int k = 0; k < NUM_CH; k++)
            wd_cnt[k] <= '0;
      end else begin
         wd_trip <= (wd_trip & ~{NUM_CH{err_clr}}) | wd_fire;
         for (int k = 0; k < NUM_CH; k++) begin
            if (cap[k])
               wd_cnt[k] <= '0;
            else if (en_s2[k] && wd_cnt[k] != WD_CYCLES)
               wd_cnt[k] <= wd_cnt[k] + 24'd1;
         end
      end
   end
`else
   assign wd_fire = '0;
`endif

endmodule

// File: tb/tb_dac_cmd_sched.sv
// tb/tb_dac_cmd_sched.sv - randomized bench for dac_cmd_sched against a transaction-level axis model
module tb_dac_cmd_sched;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [N-1:0]    ctrl_enable;
   logic [N-1:0]    cmd_ready;
   logic [16*N-1:0] cmd_data;
   logic            dac_busy;
   logic            err_clr;
   logic            dac_start;
   logic [2:0]      dac_ch;
   logic [15:0]     dac_data;
   logic [N-1:0]    pending;
   logic [N-1:0]    overrun;
   logic            ack_err;
`ifdef DAC_WATCHDOG_EN
   logic [N-1:0]    wd_trip;
`endif

   always #5 clk = ~clk;

   dac_cmd_sched #(.NUM_CH(N)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .ctrl_enable (ctrl_enable),
      .cmd_ready   (cmd_ready),
      .cmd_data    (cmd_data),
      .dac_busy    (dac_busy),
      .dac_start   (dac_start),
      .dac_ch      (dac_ch),
      .dac_data    (dac_data),
      .pending     (pending),
      .overrun     (overrun),
      .ack_err     (ack_err),
`ifdef DAC_WATCHDOG_EN
      .wd_trip     (wd_trip),
`endif
      .err_clr     (err_clr)
   );

   // Model: latest word per axis, queued flags, sticky errors, next round-robin start.
   logic [15:0] m_slot [N];
   logic [N-1:0] m_pend, m_ovr, m_en;
   logic         m_ack;
   int           m_rr;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_start(input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick(1);
         if (dac_start) seen = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_slot[k] = 16'h8000;
      m_pend = '0;
      m_ovr  = '0;
      m_ack  = 1'b0;
      m_rr   = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_start"}, dac_start, 1'b0);
      chk({tag, "_ch"}, dac_ch, 3'd0);
      chk({tag, "_data"}, dac_data, 16'h8000);
      chk({tag, "_pending"}, pending, '0);
      chk({tag, "_overrun"}, overrun, '0);
      chk({tag, "_ack_err"}, ack_err, 1'b0);
   endtask

   task automatic do_cmd(input int k, input logic [15:0] d);
      cmd_data[16*k +: 16] = d;
      cmd_ready[k] = 1'b1;
      tick(4);
      cmd_ready[k] = 1'b0;
      tick(4);
      if (m_en[k]) begin
         if (m_pend[k]) m_ovr[k] = 1'b1;
         m_pend[k] = 1'b1;
         m_slot[k] = d;
      end
   endtask

   task automatic do_en(input int k, input logic v);
      if (m_en[k] && !v) begin
         m_slot[k] = 16'h8000;
         m_pend[k] = 1'b1;
      end
      m_en[k] = v;
      ctrl_enable[k] = v;
      tick(4);
   endtask

   // Releases the DAC and expects every queued axis once, in cyclic order from m_rr.
   task automatic drain();
      int order[$];
      int a;
      int n;
      bit seen;
      for (int i = 0; i < N; i++) begin
         a = (m_rr + i) % N;
         if (m_pend[a]) order.push_back(a);
      end
      dac_busy = 1'b0;
      foreach (order[j]) begin
         a = order[j];
         wait_start(120, seen);
         chk("start_seen", seen, 1'b1);
         chk("dac_ch", dac_ch, a);
         chk("dac_data", dac_data, m_slot[a]);
         m_pend[a] = 1'b0;
         m_rr = (a + 1) % N;
         if ($urandom_range(0, 5) == 0) begin
            m_ack = 1'b1;
         end else begin
            tick($urandom_range(1, 4));
            dac_busy = 1'b1;
            tick($urandom_range(1, 8));
            dac_busy = 1'b0;
         end
      end
      n = 0;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         if (dac_start) n++;
      end
      chk("no_extra_start", n, 0);
      chk("pending_drained", pending, m_pend);
      chk("ack_err_after_drain", ack_err, m_ack);
   endtask

   task automatic phase();
      int k;
      int r;
      dac_busy = 1'b1;
      tick(3);
      repeat ($urandom_range(1, 8)) begin
         k = $urandom_range(0, N - 1);
         r = $urandom_range(0, 9);
         if (r < 2)
            do_en(k, !m_en[k]);
         else if (!m_en[k] && r < 5)
            do_en(k, 1'b1);
         else
            do_cmd(k, 16'($urandom));
      end
      tick(2);
      chk("pending_queued", pending, m_pend);
      chk("overrun_queued", overrun, m_ovr);
      chk("ack_err_queued", ack_err, m_ack);
      if ($urandom_range(0, 2) == 0) begin
         err_clr = 1'b1;
         tick(1);
         err_clr = 1'b0;
         m_ovr = '0;
         m_ack = 1'b0;
         tick(2);
         chk("overrun_cleared", overrun, m_ovr);
         chk("ack_err_cleared", ack_err, m_ack);
      end
      drain();
   endtask

   initial begin
      int  lat;
      int  n;
      bit  seen;
      ctrl_enable = '1;
      cmd_ready   = '0;
      cmd_data    = '0;
      dac_busy    = 1'b0;
      err_clr     = 1'b0;
      m_en        = '1;
      model_reset();
      tick(3);
      rstn = 1'b1;
      tick(3);
      check_reset_outputs("reset");

      // Two synchroniser flops, capture, then select: start on the fourth edge.
      cmd_data[16*2 +: 16] = 16'h9000;
      cmd_ready[2] = 1'b1;
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 10 && !seen; i++) begin
         tick(1);
         if (dac_start) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      chk("latency", lat, 4);
      chk("axis2_ch", dac_ch, 3'd2);
      chk("axis2_data", dac_data, 16'h9000);
      cmd_ready[2] = 1'b0;
      tick(1);
      dac_busy = 1'b1;
      tick(5);
      rstn = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      tick(2);
      rstn = 1'b1;
      dac_busy = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (dac_start) n++;
      end
      chk("no_start_after_reset", n, 0);
      model_reset();

      for (int p = 0; p < 30; p++) phase();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
